// File: rtl/painel_rolagem.sv
// painel_rolagem: scroll controller and N-bit universal shift register for the display panel
// Ports: clk, rst_n (async active-low); entrada_paralela image to load; carregar load request;
// rolar_en scroll enable; direcao 0 = toward MSB, 1 = toward LSB; circular 1 = rotate, 0 = zero fill;
// painel register image; s1/s0 cell select (00 load, 01 posterior, 10 anterior, 11 hold);
// ocupado high in LOAD/SCROLL; volta one-cycle pulse after every N shifts.
module painel_rolagem #(
  parameter int N = 16,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] entrada_paralela,
  input  logic         carregar,
  input  logic         rolar_en,
  input  logic         direcao,
  input  logic         circular,
  output logic [N-1:0] painel,
  output logic         s1,
  output logic         s0,
  output logic         ocupado,
  output logic         volta
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic [N-1:0] nxt;
  logic tick, shift, last;
  assign tick = state == SCROLL && presc == PW'(DIV - 1);
  // a pending load or a dropped enable swallows the tick
  assign shift = tick && !carregar && rolar_en;
  assign last = cnt == CW'(N - 1);
  assign ocupado = state != IDLE;
  always_comb begin
    state_n = state;
    {s1, s0} = 2'b11;
    case (state)
      IDLE: state_n = carregar ? LOAD : IDLE;
      LOAD: begin
        {s1, s0} = 2'b00;
        state_n = rolar_en ? SCROLL : IDLE;
      end
      SCROLL: begin
        if (carregar) state_n = LOAD;
        else if (!rolar_en) state_n = IDLE;
        else if (shift) begin
          {s1, s0} = direcao ? 2'b01 : 2'b10;
          state_n = (last && !circular) ? IDLE : SCROLL;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  for (genvar i = 0; i < N; i++) begin : g_cell
    logic ant, post;
    if (i == 0) begin : g_lo
      assign ant = circular & painel[N-1];
    end else begin : g_lo_n
      assign ant = painel[i-1];
    end
    if (i == N - 1) begin : g_hi
      assign post = circular & painel[0];
    end else begin : g_hi_n
      assign post = painel[i+1];
    end
    assign nxt[i] = s1 ? (s0 ? painel[i] : ant) : (s0 ? post : entrada_paralela[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      painel <= '0;
      presc <= '0;
      cnt <= '0;
      volta <= 1'b0;
    end else begin
      state <= state_n;
      painel <= nxt;
      presc <= (state == SCROLL && rolar_en && !carregar && !tick) ? presc + 1'b1 : '0;
      cnt <= state == LOAD ? '0 : shift ? (last ? '0 : cnt + 1'b1) : cnt;
      volta <= shift && last;
    end
  end
endmodule

// File: tb/tb_painel_rolagem.sv
// tb_painel_rolagem: self-checking bench for painel_rolagem (N=8, DIV=4)
module tb_painel_rolagem;
  localparam int N = 8;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] entrada_paralela = '0;
  logic carregar = 1'b0, rolar_en = 1'b0, direcao = 1'b0, circular = 1'b0;
  logic [N-1:0] painel;
  logic s1, s0, ocupado, volta;
  int total = 0, passed = 0;
  painel_rolagem #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .entrada_paralela(entrada_paralela), .carregar(carregar),
    .rolar_en(rolar_en), .direcao(direcao), .circular(circular), .painel(painel),
    .s1(s1), .s0(s0), .ocupado(ocupado), .volta(volta)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask
  // model: mode 0 idle, 1 load, 2 scroll; ph = cycles spent in SCROLL since the load
  int m_mode = 0, m_ph = 0, m_shifts = 0;
  logic [N-1:0] m_img = '0;
  logic m_volta = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_ph = 0; m_shifts = 0; m_img = '0; m_volta = 1'b0;
    end else begin
      m_volta = 1'b0;
      case (m_mode)
        0: if (carregar) m_mode = 1;
        1: begin
          m_img = entrada_paralela; m_ph = 0; m_shifts = 0;
          m_mode = rolar_en ? 2 : 0;
        end
        default: begin
          if (carregar) m_mode = 1;
          else if (!rolar_en) m_mode = 0;
          else begin
            if (m_ph % DIV == DIV - 1) begin
              if (direcao) m_img = circular ? {m_img[0], m_img[N-1:1]} : m_img >> 1;
              else m_img = circular ? {m_img[N-2:0], m_img[N-1]} : m_img << 1;
              m_shifts++;
              if (m_shifts % N == 0) begin
                m_volta = 1'b1;
                if (!circular) m_mode = 0;
              end
            end
            m_ph++;
          end
        end
      endcase
    end
  end
  function automatic logic [1:0] exp_sel();
    if (m_mode == 1) return 2'b00;
    if (m_mode == 2 && m_ph % DIV == DIV - 1 && !carregar && rolar_en) return direcao ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction
  always @(negedge clk) begin
    chk("painel", painel, m_img);
    chk("volta", volta, m_volta);
    chk("sel", {s1, s0}, exp_sel());
    chk("ocupado", ocupado, m_mode != 0);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic load(input logic [N-1:0] d, input logic r, input logic dr, input logic c);
    carregar = 1'b1; entrada_paralela = d; rolar_en = r; direcao = dr; circular = c;
    step(1);
    carregar = 1'b0;
    step(1);
  endtask
  initial begin
    carregar = 1'b1; entrada_paralela = 8'h81; rolar_en = 1'b1; direcao = 1'b0; circular = 1'b1;
    #3;
    chk("rst_painel", painel, 8'h00);
    chk("rst_sel", {s1, s0}, 2'b11);
    chk("rst_ocupado", ocupado, 1'b0);
    step(3);
    chk("rst_hold_painel", painel, 8'h00);
    rst_n = 1'b1;
    step(1);
    chk("held_load_sel", {s1, s0}, 2'b00);
    chk("held_load_ocupado", ocupado, 1'b1);
    carregar = 1'b0;
    step(1);
    chk("loaded", painel, 8'h81);
    step(DIV);
    chk("rot_l1", painel, 8'h03);
    step(DIV);
    chk("rot_l2", painel, 8'h06);
    step(6 * DIV);
    chk("rot_l8", painel, 8'h81);
    chk("rot_volta", volta, 1'b1);
    step(1);
    chk("rot_volta_end", volta, 1'b0);
    load(8'h81, 1'b1, 1'b1, 1'b0);
    step(DIV);
    chk("shr1", painel, 8'h40);
    step(DIV);
    chk("shr2", painel, 8'h20);
    step(6 * DIV);
    chk("shr8", painel, 8'h00);
    chk("shr_volta", volta, 1'b1);
    chk("shr_idle", ocupado, 1'b0);
    load(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("hold_load", painel, 8'hA5);
    chk("hold_sel", {s1, s0}, 2'b11);
    step(20);
    chk("hold_20", painel, 8'hA5);
    load(8'h81, 1'b1, 1'b0, 1'b1);
    step(DIV - 1);
    carregar = 1'b1; entrada_paralela = 8'h3C;
    #1;
    chk("tick_vs_load_sel", {s1, s0}, 2'b11);
    step(1);
    chk("tick_discard", painel, 8'h81);
    carregar = 1'b0;
    step(1);
    chk("reload", painel, 8'h3C);
    step(DIV);
    chk("reload_shift", painel, 8'h78);
    step(2);
    rolar_en = 1'b0;
    step(1);
    chk("freeze", painel, 8'h78);
    step(10);
    chk("freeze_10", painel, 8'h78);
    chk("freeze_idle", ocupado, 1'b0);
    load(8'h81, 1'b1, 1'b0, 1'b1);
    step(DIV);
    chk("pre_rst", painel, 8'h03);
    step(2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_painel", painel, 8'h00);
    chk("mid_rst_sel", {s1, s0}, 2'b11);
    chk("mid_rst_volta", volta, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("no_resume", painel, 8'h00);
    chk("no_resume_idle", ocupado, 1'b0);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/painel_rolagem.md
# painel_rolagem

Scroll controller and register bank for the digital display panel. Holds an N-bit panel image in a universal shift register built from the per-bit 4:1 select cells. Drives the shared select pair (s1, s0) from a small state machine and a tick prescaler. Turns a parallel load request into timed left/right scrolling, either circular or fill-with-zero, and feeds the column image to the panel driver.

## Interface
- N, 16: panel width in bits (number of register cells); N ≥ 2.
- DIV, 4: clock cycles per scroll step; DIV ≥ 1; prescaler width clog2(DIV), minimum 1 bit.
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- entrada_paralela  input  N  image to load; sampled only in LOAD.
- carregar  input  1  load request, level-sampled each edge.
- rolar_en  input  1  1 = scroll after load / keep scrolling; 0 = hold.
- direcao  input  1  0 = shift toward MSB (bit i takes bit i-1); 1 = shift toward LSB (bit i takes bit i+1).
- circular  input  1  1 = rotate (wrap end bit); 0 = shift in 0.
- painel  output  N  current panel image (register outputs).
- s1, s0  output  1 each  select pair driven to every cell: 00 load, 01 take posterior (bit i+1), 10 take anterior (bit i-1), 11 hold.
- ocupado  output  1  high in LOAD and SCROLL.
- volta  output  1  one-cycle pulse after every N completed shifts.

## Operation
- States: IDLE, LOAD, SCROLL. Encoding is free; reset state is IDLE.
- IDLE: {s1,s0}=11, painel held. carregar=1 → LOAD.
- LOAD: lasts exactly one cycle. {s1,s0}=00, so painel ← entrada_paralela at the edge.
  - Prescaler and shift counter cleared.
  - Next state: SCROLL if rolar_en=1, else IDLE.
- SCROLL: prescaler counts 0..DIV-1; tick = (prescaler == DIV-1).
  - On tick: {s1,s0}=01 if direcao=1, 10 if direcao=0; otherwise 11.
  - On each tick, shift counter increments, wrapping at N.
- Boundary cells:
  - direcao=1: bit N-1 takes bit 0 if circular=1, else 0.
  - direcao=0: bit 0 takes bit N-1 if circular=1, else 0.
- On the Nth shift:
  - volta is pulsed and the counter returns to 0.
  - circular=0 → IDLE (panel is all zeros).
  - circular=1 → stay in SCROLL.
- Priorities in SCROLL, highest first:
  1. carregar=1 → LOAD (a same-cycle tick is discarded; no shift).
  2. rolar_en=0 → IDLE, image frozen, no shift that cycle.
  3. Otherwise scroll.
- Changing direcao or circular mid-scroll takes effect on the next tick; the counter is not reset.
- Re-entering SCROLL from IDLE requires a new LOAD; resuming without a load is not supported.

## Timing
- Reset (asynchronous, immediate):
  - painel=0, state IDLE, {s1,s0}=11.
  - ocupado=0, volta=0; prescaler and counter 0.
- Release of rst_n is synchronised by the first clock edge; no action on the release edge itself.
- s1, s0 and ocupado are combinational from state and tick. painel and volta are registered.
- Load latency: carregar high before edge k (IDLE) → LOAD during cycle k..k+1 → painel = entrada_paralela after edge k+1.
- First shift: at edge k+1+DIV. Subsequent shifts every DIV edges.
- volta: high for the one cycle after the edge that performs the Nth shift.
- DIV=1: shift on every SCROLL edge.
- Reset asserted mid-scroll: all outputs return to reset values immediately; no partial shift.

## Test plan
- Reset: hold rst_n=0 while carregar=1 → painel=0, {s1,s0}=11, ocupado=0. Release rst_n → IDLE; a held carregar causes LOAD on the next edge.
- N=8, DIV=4, load 8'b1000_0001, rolar_en=1, direcao=0, circular=1:
  - painel goes 00000011, then 00000110 at 4-cycle spacing.
  - After 8 shifts, painel = 10000001 again and volta pulses once.
- Same load, direcao=1, circular=0:
  - painel goes 01000000, then 00100000, ... then 00000000 after 8 shifts.
  - volta pulses, state returns to IDLE, ocupado=0.
- Load with rolar_en=0: painel = data one edge after LOAD; {s1,s0} stays 11 thereafter; no change over 20 cycles.
- Mid-scroll events:
  - carregar=1 coincident with a tick → no shift on that edge; new data appears one edge later; counter restarts.
  - Dropping rolar_en → image frozen at the current value.
- Reset asserted during SCROLL halfway through the prescaler → painel=0 immediately; no volta pulse; scrolling does not resume after release.
